// File: rtl/xgmii_rx_frame_checker.sv
// XGMII RX frame checker: delimits /S/../T/ frames on the 64-bit bus, checks preamble,
// control characters and length, and reports per-frame results plus saturating counters.
module xgmii_rx_frame_checker #(
   parameter int MIN_LEN = 64,
   parameter int MAX_LEN = 1518
) (
   input  logic        clk156,
   input  logic        sys_rst_n,
   input  logic [63:0] xgmii_rxd,
   input  logic [7:0]  xgmii_rxc,
   output logic        rx_active,
   output logic        frame_valid,
   output logic        frame_err,
   output logic [2:0]  err_code,
   output logic [15:0] last_len,
   output logic [47:0] last_dst_mac,
   output logic [15:0] last_ethertype,
   output logic [31:0] good_cnt,
   output logic [31:0] bad_cnt
);

   typedef enum logic {ST_IDLE = 1'b0, ST_DATA = 1'b1} state_t;

   localparam logic [63:0] PREAMBLE_WORD = 64'hD5555555555555FB;
   localparam logic [63:0] IDLE_WORD     = 64'h0707070707070707;
   localparam logic [15:0] MIN_LEN_C     = 16'(MIN_LEN);
   localparam logic [15:0] MAX_LEN_C     = 16'(MAX_LEN);
   localparam logic [2:0]  ERR_NONE      = 3'd0;
   localparam logic [2:0]  ERR_PREAMBLE  = 3'd1;
   localparam logic [2:0]  ERR_CTRL      = 3'd2;
   localparam logic [2:0]  ERR_TRUNC     = 3'd3;
   localparam logic [2:0]  ERR_START     = 3'd4;
   localparam logic [2:0]  ERR_GIANT     = 3'd5;
   localparam logic [2:0]  ERR_RUNT      = 3'd6;

   function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [3:0] b);
      logic [16:0] sum;
      sum = {1'b0, a} + {13'd0, b};
      sat_add = sum[16] ? 16'hFFFF : sum[15:0];
   endfunction

   state_t      state_r, state_s;
   logic [15:0] len_r;
   logic [1:0]  widx_r;
   logic        pre_err_r, ctrl_err_r;
   logic [47:0] da_cand_r;
   logic [15:0] et_cand_r;
   logic        frame_valid_r, frame_err_r;
   logic [2:0]  err_code_r;
   logic [15:0] last_len_r, last_et_r;
   logic [47:0] last_da_r;
   logic [31:0] good_cnt_r, bad_cnt_r;

   logic        is_start_s, is_idle_s, is_term_s, pre_bad_s, tail_bad_s;
   logic [2:0]  term_k_s;
   logic        end_s, ctrl_now_s, body_s;
   logic [2:0]  end_kind_s, code_s;
   logic [15:0] len_final_s;

   // Classify the incoming word independently of the FSM state.
   always_comb begin
      is_start_s = xgmii_rxc[0] && (xgmii_rxd[7:0] == 8'hFB);
      is_idle_s  = (xgmii_rxc == 8'hFF) && (xgmii_rxd == IDLE_WORD);
      pre_bad_s  = (xgmii_rxd != PREAMBLE_WORD) || (xgmii_rxc != 8'h01);
      term_k_s   = 3'd0;
      for (int j = 7; j >= 0; j--) begin
         term_k_s = xgmii_rxc[j] ? 3'(j) : term_k_s;
      end
      is_term_s  = (xgmii_rxc != 8'h00) && (xgmii_rxd[{term_k_s, 3'b000} +: 8] == 8'hFD);
      tail_bad_s = 1'b0;
      for (int j = 0; j < 8; j++) begin
         tail_bad_s = tail_bad_s |
                      ((3'(j) > term_k_s) && !(xgmii_rxc[j] && (xgmii_rxd[8*j +: 8] == 8'h07)));
      end
   end

   // Next-state and frame-end detection.
   always_comb begin
      state_s     = state_r;
      end_s       = 1'b0;
      end_kind_s  = ERR_NONE;
      len_final_s = len_r;
      ctrl_now_s  = 1'b0;
      case (state_r)
         ST_IDLE: state_s = is_start_s ? ST_DATA : ST_IDLE;
         ST_DATA: begin
            if (is_start_s) begin
               end_s      = 1'b1;
               end_kind_s = ERR_START;
            end else if (is_idle_s) begin
               end_s      = 1'b1;
               end_kind_s = ERR_TRUNC;
               state_s    = ST_IDLE;
            end else if (is_term_s) begin
               end_s       = 1'b1;
               len_final_s = sat_add(len_r, {1'b0, term_k_s});
               ctrl_now_s  = tail_bad_s;
               state_s     = ST_IDLE;
            end else begin
               state_s = ST_DATA;
            end
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // Error priority for the frame that ends on this word.
   always_comb begin
      body_s = (state_r == ST_DATA) && !end_s;
      if (pre_err_r) begin
         code_s = ERR_PREAMBLE;
      end else if (ctrl_err_r || ctrl_now_s) begin
         code_s = ERR_CTRL;
      end else if (end_kind_s != ERR_NONE) begin
         code_s = end_kind_s;
      end else if (len_final_s > MAX_LEN_C) begin
         code_s = ERR_GIANT;
      end else if (len_final_s < MIN_LEN_C) begin
         code_s = ERR_RUNT;
      end else begin
         code_s = ERR_NONE;
      end
   end

   // FSM state register.
   always_ff @(posedge clk156) begin
      if (!sys_rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Per-frame accumulation and registered results.
   always_ff @(posedge clk156) begin
      if (!sys_rst_n) begin
         len_r         <= 16'd0;
         widx_r        <= 2'd0;
         pre_err_r     <= 1'b0;
         ctrl_err_r    <= 1'b0;
         da_cand_r     <= 48'd0;
         et_cand_r     <= 16'd0;
         frame_valid_r <= 1'b0;
         frame_err_r   <= 1'b0;
         err_code_r    <= 3'd0;
         last_len_r    <= 16'd0;
         last_da_r     <= 48'd0;
         last_et_r     <= 16'd0;
         good_cnt_r    <= 32'd0;
         bad_cnt_r     <= 32'd0;
      end else begin
         if (is_start_s) begin
            len_r      <= 16'd0;
            widx_r     <= 2'd0;
            pre_err_r  <= pre_bad_s;
            ctrl_err_r <= 1'b0;
            da_cand_r  <= 48'd0;
            et_cand_r  <= 16'd0;
         end else if (body_s) begin
            len_r      <= sat_add(len_r, 4'd8);
            widx_r     <= (widx_r == 2'd2) ? 2'd2 : widx_r + 2'd1;
            ctrl_err_r <= ctrl_err_r | (xgmii_rxc != 8'h00);
            // Only clean data words carry DA (word 0) and EtherType (word 1).
            if ((xgmii_rxc == 8'h00) && (widx_r == 2'd0)) begin
               da_cand_r <= {xgmii_rxd[7:0], xgmii_rxd[15:8], xgmii_rxd[23:16],
                             xgmii_rxd[31:24], xgmii_rxd[39:32], xgmii_rxd[47:40]};
            end
            if ((xgmii_rxc == 8'h00) && (widx_r == 2'd1)) begin
               et_cand_r <= {xgmii_rxd[39:32], xgmii_rxd[47:40]};
            end
         end
         frame_valid_r <= end_s && (code_s == ERR_NONE);
         frame_err_r   <= end_s && (code_s != ERR_NONE);
         if (end_s) begin
            err_code_r <= code_s;
            last_len_r <= len_final_s;
            last_da_r  <= da_cand_r;
            last_et_r  <= et_cand_r;
            if (code_s == ERR_NONE) begin
               good_cnt_r <= (good_cnt_r == 32'hFFFFFFFF) ? good_cnt_r : good_cnt_r + 32'd1;
            end else begin
               bad_cnt_r  <= (bad_cnt_r == 32'hFFFFFFFF) ? bad_cnt_r : bad_cnt_r + 32'd1;
            end
         end
      end
   end

   assign rx_active      = (state_r == ST_DATA);
   assign frame_valid    = frame_valid_r;
   assign frame_err      = frame_err_r;
   assign err_code       = err_code_r;
   assign last_len       = last_len_r;
   assign last_dst_mac   = last_da_r;
   assign last_ethertype = last_et_r;
   assign good_cnt       = good_cnt_r;
   assign bad_cnt        = bad_cnt_r;

endmodule

// File: tb/tb_xgmii_rx_frame_checker.sv
// Bench for xgmii_rx_frame_checker: a frame-level model built from the word stream,
// checked against the DUT on every cycle, plus literal expectations at frame ends.
module tb_xgmii_rx_frame_checker;

   localparam logic [63:0] PRE      = 64'hD5555555555555FB;
   localparam logic [63:0] PRE_BAD3 = 64'hD5555555545555FB;
   localparam logic [63:0] IDLE     = 64'h0707070707070707;
   localparam logic [63:0] DA_W     = 64'h1100FFFFFFFFFFFF;
   localparam logic [63:0] ET_W     = 64'h0045000866443322;

   logic        clk156 = 1'b0;
   logic        sys_rst_n;
   logic [63:0] xgmii_rxd;
   logic [7:0]  xgmii_rxc;
   logic        rx_active, frame_valid, frame_err;
   logic [2:0]  err_code;
   logic [15:0] last_len, last_ethertype;
   logic [47:0] last_dst_mac;
   logic [31:0] good_cnt, bad_cnt;

   xgmii_rx_frame_checker dut (
      .clk156(clk156), .sys_rst_n(sys_rst_n), .xgmii_rxd(xgmii_rxd), .xgmii_rxc(xgmii_rxc),
      .rx_active(rx_active), .frame_valid(frame_valid), .frame_err(frame_err),
      .err_code(err_code), .last_len(last_len), .last_dst_mac(last_dst_mac),
      .last_ethertype(last_ethertype), .good_cnt(good_cnt), .bad_cnt(bad_cnt)
   );

   always #5 clk156 = ~clk156;

   int n_checks = 0;
   int n_err    = 0;
   bit chk_en   = 1'b0;

   typedef struct packed {
      logic [63:0] d;
      logic        norm;
   } word_t;

   word_t       m_words[$];
   bit          m_in, m_pre, m_ctrl;
   logic        exp_active, exp_valid, exp_err;
   logic [2:0]  exp_code;
   logic [15:0] exp_len, exp_et;
   logic [47:0] exp_da;
   logic [31:0] exp_good, exp_bad;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] lane_of(input logic [63:0] w, input int k);
      return w[8*k +: 8];
   endfunction

   task automatic model_finish(input int kind, input int len);
      int         l;
      logic [2:0] code;
      logic [63:0] w;
      l = (len > 65535) ? 65535 : len;
      if (m_pre)           code = 3'd1;
      else if (m_ctrl)     code = 3'd2;
      else if (kind != 0)  code = 3'(kind);
      else if (l > 1518)   code = 3'd5;
      else if (l < 64)     code = 3'd6;
      else                 code = 3'd0;
      exp_code = code;
      exp_len  = 16'(l);
      exp_da   = 48'd0;
      exp_et   = 16'd0;
      if (m_words.size() >= 1 && m_words[0].norm) begin
         w = m_words[0].d;
         exp_da = {lane_of(w, 0), lane_of(w, 1), lane_of(w, 2),
                   lane_of(w, 3), lane_of(w, 4), lane_of(w, 5)};
      end
      if (m_words.size() >= 2 && m_words[1].norm) begin
         w = m_words[1].d;
         exp_et = {lane_of(w, 12 - 8), lane_of(w, 13 - 8)};
      end
      if (code == 3'd0) begin
         exp_valid = 1'b1;
         if (exp_good != 32'hFFFFFFFF) exp_good = exp_good + 32'd1;
      end else begin
         exp_err = 1'b1;
         if (exp_bad != 32'hFFFFFFFF) exp_bad = exp_bad + 32'd1;
      end
      m_in = 1'b0;
      m_words.delete();
   endtask

   task automatic model_step(input logic [63:0] d, input logic [7:0] c, input logic rst_n);
      bit start;
      int k;
      exp_valid = 1'b0;
      exp_err   = 1'b0;
      if (!rst_n) begin
         m_in = 1'b0; m_pre = 1'b0; m_ctrl = 1'b0;
         m_words.delete();
         exp_code = 3'd0; exp_len = 16'd0; exp_da = 48'd0; exp_et = 16'd0;
         exp_good = 32'd0; exp_bad = 32'd0;
      end else begin
         start = c[0] && (d[7:0] == 8'hFB);
         if (m_in) begin
            if (start) begin
               model_finish(4, 8 * m_words.size());
            end else if (c == 8'hFF && d == IDLE) begin
               model_finish(3, 8 * m_words.size());
            end else begin
               k = -1;
               for (int j = 0; j < 8; j++) if (c[j] && k < 0) k = j;
               if (k >= 0 && lane_of(d, k) == 8'hFD) begin
                  for (int j = k + 1; j < 8; j++)
                     if (!(c[j] && lane_of(d, j) == 8'h07)) m_ctrl = 1'b1;
                  model_finish(0, 8 * m_words.size() + k);
               end else begin
                  if (c != 8'h00) m_ctrl = 1'b1;
                  m_words.push_back({d, c == 8'h00});
               end
            end
         end
         if (start) begin
            m_in   = 1'b1;
            m_pre  = (d != PRE) || (c != 8'h01);
            m_ctrl = 1'b0;
            m_words.delete();
         end
      end
      exp_active = m_in;
   endtask

   task automatic cyc(input logic [63:0] d, input logic [7:0] c, input logic rst_n);
      xgmii_rxd = d;
      xgmii_rxc = c;
      sys_rst_n = rst_n;
      @(posedge clk156);
      model_step(d, c, rst_n);
      #1;
   endtask

   task automatic body(input int n, input int ctrl_idx);
      logic [63:0] d;
      logic [7:0]  c;
      logic [7:0]  b;
      for (int i = 0; i < n; i++) begin
         b = 8'(i);
         d = (i == 0) ? DA_W : (i == 1) ? ET_W : {8{b}};
         c = 8'h00;
         if (i == ctrl_idx) begin
            d[31:24] = 8'hFE;
            c = 8'h08;
         end
         cyc(d, c, 1'b1);
      end
   endtask

   task automatic term(input int k);
      logic [63:0] d;
      logic [7:0]  c;
      for (int j = 0; j < 8; j++) begin
         if (j < k) begin
            d[8*j +: 8] = 8'h10 + 8'(j);
            c[j] = 1'b0;
         end else begin
            d[8*j +: 8] = (j == k) ? 8'hFD : 8'h07;
            c[j] = 1'b1;
         end
      end
      cyc(d, c, 1'b1);
   endtask

   task automatic frame(input int n, input int k, input logic [63:0] pre, input int ctrl_idx);
      cyc(pre, 8'h01, 1'b1);
      body(n, ctrl_idx);
      term(k);
   endtask

   task automatic gap(input int n);
      for (int i = 0; i < n; i++) cyc(IDLE, 8'hFF, 1'b1);
   endtask

   // Every-cycle comparison of all outputs against the model.
   initial begin
      forever begin
         @(negedge clk156);
         if (chk_en) begin
            chk("rx_active", 64'(rx_active), 64'(exp_active));
            chk("frame_valid", 64'(frame_valid), 64'(exp_valid));
            chk("frame_err", 64'(frame_err), 64'(exp_err));
            chk("exclusive_pulse", 64'(frame_valid & frame_err), 64'd0);
            chk("err_code", 64'(err_code), 64'(exp_code));
            chk("last_len", 64'(last_len), 64'(exp_len));
            chk("last_dst_mac", 64'(last_dst_mac), 64'(exp_da));
            chk("last_ethertype", 64'(last_ethertype), 64'(exp_et));
            chk("good_cnt", 64'(good_cnt), 64'(exp_good));
            chk("bad_cnt", 64'(bad_cnt), 64'(exp_bad));
         end
      end
   end

   initial begin
      xgmii_rxd = IDLE;
      xgmii_rxc = 8'hFF;
      sys_rst_n = 1'b0;
      cyc(IDLE, 8'hFF, 1'b0);
      chk_en = 1'b1;
      cyc(IDLE, 8'hFF, 1'b0);
      chk("reset_good", 64'(good_cnt), 64'd0);
      chk("reset_active", 64'(rx_active), 64'd0);
      gap(2);
      cyc(64'h07070707070707FD, 8'hFF, 1'b1);
      cyc(64'h07070707070707FE, 8'hFF, 1'b1);
      chk("idle_stray_active", 64'(rx_active), 64'd0);

      frame(8, 0, PRE, -1);
      chk("good_valid", 64'(frame_valid), 64'd1);
      chk("good_len", 64'(last_len), 64'd64);
      chk("good_da", 64'(last_dst_mac), 64'hFFFFFFFFFFFF);
      chk("good_et", 64'(last_ethertype), 64'h0800);
      chk("good_code", 64'(err_code), 64'd0);
      chk("good_cnt1", 64'(good_cnt), 64'd1);
      gap(2);

      frame(7, 4, PRE, -1);
      chk("runt_err", 64'(frame_err), 64'd1);
      chk("runt_code", 64'(err_code), 64'd6);
      chk("runt_len", 64'(last_len), 64'd60);
      chk("runt_bad", 64'(bad_cnt), 64'd1);
      chk("runt_good", 64'(good_cnt), 64'd1);
      gap(1);

      frame(8, 0, PRE, 4);
      chk("ctrl_code", 64'(err_code), 64'd2);
      chk("ctrl_len", 64'(last_len), 64'd64);
      gap(1);

      frame(8, 0, PRE_BAD3, -1);
      chk("pre_code", 64'(err_code), 64'd1);
      gap(1);

      frame(190, 0, PRE, -1);
      chk("giant_code", 64'(err_code), 64'd5);
      chk("giant_len", 64'(last_len), 64'd1520);
      gap(1);

      cyc(PRE, 8'h01, 1'b1);
      body(3, -1);
      cyc(IDLE, 8'hFF, 1'b1);
      chk("trunc_code", 64'(err_code), 64'd3);
      chk("trunc_len", 64'(last_len), 64'd24);
      gap(1);

      cyc(PRE, 8'h01, 1'b1);
      body(3, -1);
      cyc(PRE, 8'h01, 1'b1);
      chk("start_code", 64'(err_code), 64'd4);
      chk("start_len", 64'(last_len), 64'd24);
      chk("start_active", 64'(rx_active), 64'd1);
      body(8, -1);
      term(0);
      chk("after_start_code", 64'(err_code), 64'd0);
      chk("after_start_valid", 64'(frame_valid), 64'd1);
      chk("totals_good", 64'(good_cnt), 64'd2);
      chk("totals_bad", 64'(bad_cnt), 64'd6);
      gap(2);

      cyc(PRE, 8'h01, 1'b1);
      body(3, -1);
      cyc(64'h3333333333333333, 8'h00, 1'b0);
      chk("rst_good", 64'(good_cnt), 64'd0);
      chk("rst_bad", 64'(bad_cnt), 64'd0);
      chk("rst_len", 64'(last_len), 64'd0);
      chk("rst_active", 64'(rx_active), 64'd0);
      body(4, -1);
      term(0);
      gap(1);
      frame(8, 0, PRE, -1);
      chk("post_rst_good", 64'(good_cnt), 64'd1);
      gap(3);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/xgmii_rx_frame_checker.md
Name: xgmii_rx_frame_checker

Overview:
Receive-side counterpart of the XGMII test-frame generator. It sits on the 64-bit XGMII RX bus of one 10GBASE-R port, after the lane-0 alignment stage, in the clk156 domain. It delimits frames (/S/ … /T/), checks preamble, control characters and length, and extracts the destination MAC and EtherType. It exposes per-frame result pulses and saturating good/bad frame counters for LEDs and debug.

Parameters:
MIN_LEN, 64, minimum legal frame length in bytes (DA through FCS)
MAX_LEN, 1518, maximum legal frame length in bytes

Ports:
clk156  in  1  156.25 MHz XGMII clock
sys_rst_n  in  1  synchronous, active-low reset
xgmii_rxd  in  64  RX data; lane k = bits [8k+7:8k]; lane 0 is first on the wire
xgmii_rxc  in  8  RX control; bit k flags lane k as a control character
rx_active  out  1  high while in DATA state
frame_valid  out  1  one-cycle pulse: frame ended with no error
frame_err  out  1  one-cycle pulse: frame ended with an error
err_code  out  3  0 none, 1 PREAMBLE, 2 CTRL, 3 TRUNC, 4 START, 5 GIANT, 6 RUNT; held until next pulse
last_len  out  16  byte length of last completed frame, good or bad
last_dst_mac  out  48  DA of last frame; lane 0 of DA word is the MSB
last_ethertype  out  16  bytes 12 and 13 of the last frame, {byte12, byte13}
good_cnt  out  32  count of good frames, saturating
bad_cnt  out  32  count of errored frames, saturating

Behaviour:
- Reset (sys_rst_n=0 at clk156 edge): state IDLE. All outputs 0. Internal length, sticky error and word index cleared. A frame in progress at reset is discarded: no pulse, no counter change.
- States: IDLE, DATA.
- Start word: rxc[0]=1 and rxd[7:0]=8'hFB.
  - In IDLE, a start word moves the FSM to DATA and clears len and the word index.
  - If rxd != 64'hD5555555555555FB or rxc != 8'h01, PREAMBLE is set sticky. The frame is still delimited.
- DATA, normal word (rxc=0x00): len += 8 (saturates at 16'hFFFF); word index += 1.
  - Data word 0 lanes 0–5 are latched as DA candidate.
  - Data word 1 lanes 4–5 are latched as EtherType candidate.
- DATA, terminate: the lowest set rxc bit k has rxd lane k = 8'hFD.
  - len_final = len + k.
  - Every lane above k must have rxc=1 and data 8'h07. Otherwise CTRL is set.
  - Every lane below k must have rxc=0. Otherwise CTRL is set.
  - FSM returns to IDLE.
- DATA, any other control character (e.g. 8'hFE), or rxc set without a valid FD: CTRL is set sticky and the word counts as 8 bytes.
- DATA, all-idle word (rxc=0xFF, all lanes 07): frame ends with TRUNC; len_final = len; FSM goes to IDLE.
- DATA, new start word: the current frame ends with START. A new frame begins on the same word, with the preamble checked as above.
- End-of-frame evaluation, first match wins: PREAMBLE > CTRL > TRUNC/START > GIANT (len_final > MAX_LEN) > RUNT (len_final < MIN_LEN).
- Latency: the pulse, err_code, last_len, last_dst_mac, last_ethertype and counters all update on the clock edge after the ending word is sampled (registered, 1 cycle).
- frame_valid and frame_err are never high together.
- DA and EtherType are committed on every frame end. Fields not received are committed as 0.
- Counters saturate at 32'hFFFFFFFF and never wrap.
- IDLE ignores every non-start word, including stray FD and FE.
- Simultaneous end (START) and new start on one word: the pulse for the old frame is issued. rx_active stays 1.

Test Plan:
- 64-byte broadcast UDP frame (start word; DA word 64'h1100FFFFFFFFFFFF; EtherType word 64'h0045000866443322; 8 data words; FD in lane 0 of 64'h07070707070707FD with rxc=FF) -> frame_valid pulse 1 cycle after the FD word; last_len=64; last_dst_mac=48'hFFFFFFFFFFFF; last_ethertype=16'h0800; good_cnt=1; err_code=0.
- Same frame with 7 data words and FD in lane 4 -> len 60; frame_err; err_code=6 (RUNT); bad_cnt=1; good_cnt unchanged.
- 64-byte frame with rxc[3]=1 and lane 3 = 8'hFE in data word 4 -> frame_err at FD; err_code=2 (CTRL); last_len=64.
- Start word with lane 3 = 8'h54 -> err_code=1 (PREAMBLE) at frame end, even though length is legal.
- 190 data words, then FD in lane 0 -> last_len=1520; err_code=5 (GIANT). Separately, idle word after 3 data words -> err_code=3 (TRUNC), last_len=24. Separately, new start after 3 data words -> err_code=4 (START), then the following frame is checked normally.
- sys_rst_n low for 1 cycle during data word 3 -> no pulse; all outputs 0. Next 64-byte good frame -> good_cnt=1.
